// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD stopwatch controller.
//   sw_state_t : controller FSM states (IDLE / RUN / PAUSE)
//   BCD_MAX    : largest legal value of a single BCD digit
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the stopwatch count.
// Ports:
//   clk    : clock, rising edge
//   clr    : synchronous active-high clear, wins over en
//   en     : advance this digit on the next edge (9 wraps to 0)
//   q      : current digit value, always 0..9
//   is_max : combinational, high while q == 9 (feeds the carry chain)
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       is_max
);

  assign is_max = (q == BCD_MAX);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= is_max ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: start/stop/pause FSM, tick prescaler, NDIG
// cascaded BCD digits with carry chain, wrap pulse and optional lap hold.
// Optional feature macro: BCD_LAP_HOLD_EN (lap-hold display capture).
// Parameters:
//   PRESCALE : clk cycles per count tick (>= 2)
//   NDIG     : number of BCD digits (>= 1)
// Ports:
//   clk     : clock, rising edge
//   clr     : synchronous active-high reset
//   start   : run request (level)
//   stop    : pause request (level, wins over start in RUN)
//   lap     : lap-hold toggle request (level; ignored without the macro)
//   tick    : count-advance strobe, decoded from state and prescaler
//   dig_en  : per-digit increment enables
//   count   : live BCD value, digit k at [4k+3:4k]
//   disp    : displayed BCD value (count, or frozen lap value)
//   running : high while in RUN
//   ovf     : one-cycle pulse after the count wraps from all 9s to 0
//
// state | meaning
// IDLE  | cleared, prescaler held at 0, waiting for start
// RUN   | prescaler advancing, count ticks every PRESCALE cycles
// PAUSE | count and prescaler frozen, waiting for start to resume
module bcd_stopwatch_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int PRESCALE = 10,
  parameter int NDIG     = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              lap,
  output logic              tick,
  output logic [NDIG-1:0]   dig_en,
  output logic [4*NDIG-1:0] count,
  output logic [4*NDIG-1:0] disp,
  output logic              running,
  output logic              ovf
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  sw_state_t       state;
  logic [PW-1:0]   pre;
  logic [NDIG-1:0] is_max;
  logic [NDIG-1:0] en_chain;
  logic            carry;
  logic            wrap;

  assign tick = (state == RUN) && (pre == PRE_LAST);

  // Ripple carry: digit k advances when tick and every lower digit is 9.
  // Whatever carries out of the top digit is a full-scale wrap.
  always_comb begin
    en_chain = '0;
    carry    = tick;
    for (int k = 0; k < NDIG; k++) begin
      en_chain[k] = carry;
      carry       = carry & is_max[k];
    end
    wrap = carry;
  end

  assign dig_en = en_chain;

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    bcd_digit u_digit (
      .clk    (clk),
      .clr    (clr),
      .en     (dig_en[k]),
      .q      (count[4*k+3:4*k]),
      .is_max (is_max[k])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      pre     <= '0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf <= wrap;
      unique case (state)
        IDLE: begin
          pre <= '0;
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
          if (stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          // pre holds so the interrupted period finishes after resume
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          pre     <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCD_LAP_HOLD_EN
  logic              hold;
  logic [4*NDIG-1:0] disp_r;

  // Capture takes the value visible in the cycle lap is seen, before any
  // coincident tick lands.
  always_ff @(posedge clk) begin
    if (clr) begin
      hold   <= 1'b0;
      disp_r <= '0;
    end else if (lap && (state == RUN || state == PAUSE)) begin
      hold <= ~hold;
      if (!hold) begin
        disp_r <= count;
      end
    end
  end

  assign disp = hold ? disp_r : count;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = count;
`endif

endmodule
